// File: rtl/usb_bulk_pattern_src_if.sv
// AXI4-Stream byte channel between the pattern source and the USB BULK IN endpoint.
// The master drives valid/last/data; the slave returns ready.
interface usb_bulk_pattern_src_if;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic [7:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/usb_bulk_pattern_src.sv
// Bulk IN test-pattern source: bursts of fixed-length packets of counting or
// LFSR bytes, with a programmable packet count and a fixed inter-packet gap.
module usb_bulk_pattern_src #(
  parameter int         MAX_PACKET = 512,
  parameter int         LEN_BITS   = 10,
  parameter int         GAP        = 2,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic                clock,
  input  logic                areset_n,
  input  logic                enable_i,
  input  logic                mode_i,
  input  logic [LEN_BITS-1:0] length_i,
  input  logic [15:0]         count_i,
  usb_bulk_pattern_src_if.master m,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         pkts_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int                  GAP_W    = $clog2(GAP + 2);
  localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LEN_BITS-1:0] MAX_LEN  = LEN_BITS'(MAX_PACKET);

  function automatic logic [LEN_BITS-1:0] clamp_len(input logic [LEN_BITS-1:0] l);
    if (l == '0)
      clamp_len = LEN_BITS'(1);
    else if (l > MAX_LEN)
      clamp_len = MAX_LEN;
    else
      clamp_len = l;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] p);
    sat_inc16 = (p == 16'hFFFF) ? p : p + 16'd1;
  endfunction

  // 8-bit Galois LFSR, right shift, taps 8'hB8.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    lfsr_next = {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // Assertion is immediate; release is retimed to the clock so all state
  // leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  logic [1:0]          state;
  logic                mode_q;
  logic [LEN_BITS-1:0] len_q;
  logic [15:0]         cnt_q;
  logic [LEN_BITS-1:0] idx_q;
  logic [GAP_W-1:0]    gap_q;
  logic [7:0]          byte_q;
  logic [7:0]          lfsr_q;
  logic [15:0]         pkts_q;
  logic                done_q;

  logic        send_st;
  logic        beat_ok;
  logic        last_beat;
  logic [15:0] pkts_inc;

  assign send_st   = (state == S_SEND);
  assign last_beat = (idx_q == len_q - LEN_BITS'(1));
  assign beat_ok   = send_st && m.tready;
  assign pkts_inc  = sat_inc16(pkts_q);

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      len_q  <= LEN_BITS'(1);
      cnt_q  <= 16'd0;
      idx_q  <= '0;
      gap_q  <= '0;
      byte_q <= 8'h00;
      lfsr_q <= SEED;
      pkts_q <= 16'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable_i) begin
            state  <= S_SEND;
            mode_q <= mode_i;
            len_q  <= clamp_len(length_i);
            cnt_q  <= count_i;
            idx_q  <= '0;
            byte_q <= 8'h00;
            lfsr_q <= SEED;
            pkts_q <= 16'd0;
          end
        end
        S_SEND: begin
          if (beat_ok) begin
            // Both generators run; mode_q only picks which one is visible.
            byte_q <= byte_q + 8'd1;
            lfsr_q <= lfsr_next(lfsr_q);
            if (last_beat) begin
              idx_q  <= '0;
              pkts_q <= pkts_inc;
              if ((cnt_q != 16'd0) && (pkts_inc == cnt_q)) begin
                done_q <= 1'b1;
                state  <= S_DONE;
              end else if (!enable_i) begin
                state <= S_IDLE;
              end else if (GAP != 0) begin
                state <= S_GAP;
                gap_q <= GAP_LOAD;
              end
            end else begin
              idx_q <= idx_q + LEN_BITS'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0)
            state <= enable_i ? S_SEND : S_IDLE;
          else
            gap_q <= gap_q - GAP_W'(1);
        end
        S_DONE: begin
          if (!enable_i)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs derive from registered state only, so they hold while stalled.
  assign m.tvalid = send_st;
  assign m.tlast  = send_st && last_beat;
  assign m.tdata  = mode_q ? lfsr_q : byte_q;
  assign busy_o   = (state == S_SEND) || (state == S_GAP);
  assign done_o   = done_q;
  assign pkts_o   = pkts_q;

endmodule

// File: tb/tb_usb_bulk_pattern_src.sv
// Randomized bench for usb_bulk_pattern_src: expected bytes, tlast positions,
// gaps and packet counts come from a run-level model of the packet stream.
module tb_usb_bulk_pattern_src;

  localparam int         MAX_PACKET = 512;
  localparam int         LEN_BITS   = 10;
  localparam int         GAP        = 2;
  localparam logic [7:0] SEED       = 8'hA5;

  logic                clock;
  logic                areset_n;
  logic                enable_i;
  logic                mode_i;
  logic [LEN_BITS-1:0] length_i;
  logic [15:0]         count_i;
  logic                busy_o;
  logic                done_o;
  logic [15:0]         pkts_o;

  int vec_cnt;
  int err_cnt;

  usb_bulk_pattern_src_if bus ();

  usb_bulk_pattern_src #(
    .MAX_PACKET (MAX_PACKET),
    .LEN_BITS   (LEN_BITS),
    .GAP        (GAP),
    .SEED       (SEED)
  ) dut (
    .clock    (clock),
    .areset_n (areset_n),
    .enable_i (enable_i),
    .mode_i   (mode_i),
    .length_i (length_i),
    .count_i  (count_i),
    .m        (bus),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .pkts_o   (pkts_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next LFSR byte: halve, and fold in the tap pattern when an odd value is shifted.
  function automatic logic [7:0] galois(input logic [7:0] v);
    int x;
    x = int'(v) / 2;
    if (int'(v) % 2 == 1)
      x = x ^ 'hB8;
    return 8'(x);
  endfunction

  // One run; drop_at >= 0 means continuous mode with enable_i released once
  // that many beats have been offered for acceptance.
  task automatic run_burst(input bit md, input logic [LEN_BITS-1:0] len_in, input int pkts_req,
                           input bit rnd_ready, input int drop_at);
    int eff_len, k, total, exp_pkts, idle_run, cyc;
    bit after_last, prev_stall, acc, last, dropped, timed_out;
    logic [7:0] exp_byte, prev_data;
    logic prev_last;
    eff_len   = (len_in == 0) ? 1 : ((int'(len_in) > MAX_PACKET) ? MAX_PACKET : int'(len_in));
    exp_pkts  = (drop_at >= 0) ? (drop_at + eff_len - 1) / eff_len : pkts_req;
    total     = exp_pkts * eff_len;
    exp_byte  = md ? SEED : 8'h00;
    k = 0; idle_run = 0; cyc = 0;
    after_last = 0; prev_stall = 0; dropped = 0; timed_out = 0;
    prev_data = 8'h00; prev_last = 1'b0;

    @(negedge clock);
    enable_i   = 1'b1;
    mode_i     = md;
    length_i   = len_in;
    count_i    = (drop_at >= 0) ? 16'd0 : 16'(pkts_req);
    bus.tready = 1'b0;
    @(negedge clock);
    check_eq("first_valid", 32'(bus.tvalid), 32'd1);
    mode_i   = ~md;
    length_i = LEN_BITS'($urandom);
    count_i  = 16'($urandom);

    forever begin
      if (k == total) begin
        check_eq("end_done", 32'(done_o), 32'(drop_at < 0));
        check_eq("end_valid", 32'(bus.tvalid), 32'd0);
        check_eq("end_busy", 32'(busy_o), 32'd0);
        check_eq("end_pkts", 32'(pkts_o), 32'(exp_pkts));
        break;
      end
      if (cyc > 20000) begin
        check_eq("timeout", 32'(cyc), 32'd0);
        timed_out = 1;
        break;
      end
      check_eq("pkts_run", 32'(pkts_o), 32'(k / eff_len));
      check_eq("no_done", 32'(done_o), 32'd0);
      if (prev_stall) begin
        check_eq("stall_valid", 32'(bus.tvalid), 32'd1);
        check_eq("stall_data", 32'(bus.tdata), 32'(prev_data));
        check_eq("stall_last", 32'(bus.tlast), 32'(prev_last));
      end
      if (bus.tvalid) begin
        check_eq("tdata", 32'(bus.tdata), 32'(exp_byte));
        check_eq("tlast", 32'(bus.tlast), 32'((k % eff_len) == eff_len - 1));
        check_eq("busy_send", 32'(busy_o), 32'd1);
        if (after_last) begin
          check_eq("gap_len", 32'(idle_run), 32'(GAP));
          after_last = 0;
        end
        idle_run = 0;
      end else begin
        idle_run++;
        check_eq("busy_gap", 32'(busy_o), 32'd1);
      end

      bus.tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      acc        = bus.tvalid && bus.tready;
      prev_stall = bus.tvalid && !bus.tready;
      prev_data  = bus.tdata;
      prev_last  = bus.tlast;
      if (acc) begin
        last       = ((k % eff_len) == eff_len - 1);
        k++;
        exp_byte   = md ? galois(exp_byte) : exp_byte + 8'd1;
        after_last = last;
      end
      if (drop_at >= 0 && !dropped && k == drop_at) begin
        enable_i = 1'b0;
        dropped  = 1;
      end
      @(negedge clock);
      cyc++;
    end

    if (!timed_out) begin
      repeat (3) begin
        @(negedge clock);
        check_eq("hold_valid", 32'(bus.tvalid), 32'd0);
        check_eq("hold_busy", 32'(busy_o), 32'd0);
        check_eq("hold_done", 32'(done_o), 32'd0);
      end
    end
    enable_i = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("idle_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int md, ln, cn, dr;
    vec_cnt    = 0;
    err_cnt    = 0;
    areset_n   = 1'b1;
    enable_i   = 1'b0;
    mode_i     = 1'b0;
    length_i   = '0;
    count_i    = 16'd0;
    bus.tready = 1'b0;
    #1 areset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_valid", 32'(bus.tvalid), 32'd0);
    check_eq("rst_last", 32'(bus.tlast), 32'd0);
    check_eq("rst_data", 32'(bus.tdata), 32'h00);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_pkts", 32'(pkts_o), 32'd0);
    areset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("post_rst_valid", 32'(bus.tvalid), 32'd0);

    run_burst(1'b0, 10'd4, 2, 1'b0, -1);
    run_burst(1'b1, 10'd3, 1, 1'b0, -1);
    run_burst(1'b0, 10'd8, 1, 1'b1, -1);
    run_burst(1'b0, 10'd2, 0, 1'b0, 5);
    run_burst(1'b0, 10'd0, 3, 1'b0, -1);
    run_burst(1'b1, 10'd1000, 1, 1'b0, -1);

    // Reset in the middle of a packet, then restart in both modes.
    @(negedge clock);
    enable_i   = 1'b1;
    mode_i     = 1'b0;
    length_i   = 10'd8;
    count_i    = 16'd0;
    bus.tready = 1'b1;
    repeat (4) @(negedge clock);
    check_eq("pre_rst_valid", 32'(bus.tvalid), 32'd1);
    #2 areset_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.tvalid), 32'd0);
    check_eq("arst_pkts", 32'(pkts_o), 32'd0);
    check_eq("arst_data", 32'(bus.tdata), 32'h00);
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    enable_i = 1'b0;
    @(negedge clock);
    areset_n = 1'b1;
    repeat (3) @(negedge clock);
    run_burst(1'b0, 10'd3, 1, 1'b0, -1);
    run_burst(1'b1, 10'd5, 2, 1'b1, -1);

    for (int r = 0; r < 10; r++) begin
      md = $urandom_range(0, 1);
      ln = $urandom_range(1, 12);
      cn = $urandom_range(1, 4);
      dr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, ln * 3) : -1;
      run_burst(md[0], LEN_BITS'(ln), (dr >= 0) ? 0 : cn, 1'b1, dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
